// File: rtl/scan_read_streamer_if.sv
// Signal bundle between the scan read streamer and its neighbours:
// transfer control, scan generator, SRAM read port and output stream.
interface scan_read_streamer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [15:0]       num_words;
  logic              busy;
  logic              done;
  logic              step;
  logic [ADDR_W-1:0] addr_in;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  // Streamer side
  modport master (
    input  start, num_words, addr_in, mem_rdata, out_ready,
    output busy, done, step, mem_ren, mem_raddr, out_valid, out_data, out_last
  );

  // Environment side (control, generator, SRAM, downstream sink)
  modport slave (
    output start, num_words, addr_in, mem_rdata, out_ready,
    input  busy, done, step, mem_ren, mem_raddr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/scan_read_streamer.sv
// Reads num_words SRAM words at the addresses supplied by the scan generator and
// streams them out in order; a credit-limited FWFT FIFO absorbs backpressure.
module scan_read_streamer #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  scan_read_streamer_if.master        strm_io
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_lat
    $error("scan_read_streamer: RD_LAT must be in 1..4");
  end
  if (FIFO_DEPTH < RD_LAT + 2) begin : g_chk_depth
    $error("scan_read_streamer: FIFO_DEPTH must be >= RD_LAT+2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  returned_q, returned_d;
  logic [CNT_W-1:0]  accepted_q, accepted_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [RD_LAT-1:0] vld_q;
  fifo_entry_t       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  count_q;

  logic              issue_c, push_c, pop_c, valid_c;
  logic [CRD_W-1:0]  credit_use_c;
  logic [ADDR_W-1:0] raddr_c;
  fifo_entry_t       push_entry_c, head_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits count reads in flight plus words parked in the FIFO, from registered state only
  assign credit_use_c = CRD_W'(issued_q - returned_q) + CRD_W'(count_q);
  assign issue_c      = (state_q == S_RUN) && (issued_q < num_q) &&
                        (credit_use_c < CRD_W'(FIFO_DEPTH));
  assign push_c       = vld_q[RD_LAT-1];
  assign valid_c      = (count_q != '0);
  assign pop_c        = valid_c && strm_io.out_ready;
  assign raddr_c      = issue_c ? strm_io.addr_in : '0;

  assign push_entry_c.last = (returned_q == num_q - CNT_W'(1));
  assign push_entry_c.data = strm_io.mem_rdata;
  assign head_c            = fifo_q[rd_ptr_q];

  assign strm_io.mem_ren   = issue_c;
  assign strm_io.step      = issue_c;
  assign strm_io.mem_raddr = raddr_c;
  assign strm_io.busy      = busy_q;
  assign strm_io.done      = done_q;
  assign strm_io.out_valid = valid_c;
  assign strm_io.out_data  = valid_c ? head_c.data : '0;
  assign strm_io.out_last  = valid_c && head_c.last;

  // Next-state and counter logic
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    accepted_d = accepted_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (issue_c) issued_d   = issued_q + CNT_W'(1);
    if (push_c)  returned_d = returned_q + CNT_W'(1);
    if (pop_c)   accepted_d = accepted_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        // done_q high means this is the done cycle, where start is still ignored
        if (strm_io.start && !done_q) begin
          num_d      = strm_io.num_words;
          issued_d   = '0;
          returned_d = '0;
          accepted_d = '0;
          if (strm_io.num_words == '0) begin
            // Empty transfer drains instantly: done next cycle, busy never rises
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue_c && (issued_d == num_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (accepted_d == num_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      accepted_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      accepted_q <= accepted_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Read-return tracking and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q <= RD_LAT'({vld_q, issue_c});
      if (push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_c, pop_c})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until the occupancy count covers them
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= push_entry_c;
  end

endmodule
